// File: rtl/reg_file.sv
// 32 x 32-bit register file with x0 hardwired to zero and a 31-cycle clear sequence.
// Optional same-cycle write-to-read bypass when REG_FILE_BYPASS_EN is defined.
module reg_file (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] rd_addr1,
    input  logic [31:0] rd_addr2,
    output logic [31:0] rd_data1,
    output logic [31:0] rd_data2,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic        clear_req,
    output logic        busy,
    output logic        addr_err,
    output logic [15:0] wr_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t      state_q;
    logic [4:0]  idx_q;
    logic        busy_q;
    logic        err_q, err_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] mem_q [32];

    logic wr_ok;
    logic commit;
    logic addr_bad;

    assign wr_ok    = (wr_addr[31:5] == 27'd0) && (wr_addr[4:0] != 5'd0);
    assign commit   = reset_n && (state_q == IDLE) && !clear_req && wr_ok;
    assign addr_bad = (|rd_addr1[31:5]) || (|rd_addr2[31:5]) || (|wr_addr[31:5]);

    function automatic logic [31:0] rd_port(input logic [31:0] a);
        logic [31:0] v;
        v = '0;
        if (!reset_n || state_q == CLEAR || a[31:5] != 27'd0 || a[4:0] == 5'd0) begin
            v = '0;
`ifdef REG_FILE_BYPASS_EN
        end else if (commit && a[4:0] == wr_addr[4:0]) begin
            v = wr_data;
`endif
        end else begin
            v = mem_q[a[4:0]];
        end
        return v;
    endfunction

    always_comb begin
        rd_data1 = rd_port(rd_addr1);
        rd_data2 = rd_port(rd_addr2);
    end

    // Saturating counter: stops at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (commit && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
        err_d = err_q | addr_bad;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= 5'd0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (clear_req) begin
                        state_q <= CLEAR;
                        idx_q   <= 5'd1;
                        busy_q  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (idx_q == 5'd31) begin
                        state_q <= IDLE;
                        idx_q   <= 5'd0;
                        busy_q  <= 1'b0;
                    end else begin
                        idx_q <= idx_q + 5'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    idx_q   <= 5'd0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Entry 0 is only ever reset, so x0 stays zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= '0;
            end
        end else if (commit) begin
            mem_q[wr_addr[4:0]] <= wr_data;
        end else if (state_q == CLEAR) begin
            mem_q[idx_q] <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
            cnt_q <= 16'd0;
        end else begin
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign busy     = busy_q;
    assign addr_err = err_q;
    assign wr_count = cnt_q;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vectors, clear/reset sequences,
// randomized traffic against an array-based reference model, counter saturation.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] rd_addr1 = '0;
    logic [31:0] rd_addr2 = '0;
    logic [31:0] rd_data1;
    logic [31:0] rd_data2;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        clear_req = 1'b0;
    logic        busy;
    logic        addr_err;
    logic [15:0] wr_count;

    int nchecks = 0;
    int nerrs   = 0;

    reg_file dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .clear_req(clear_req),
        .busy     (busy),
        .addr_err (addr_err),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    // Reference model
    logic [31:0] m_mem [32];
    int          m_busy;
    bit          m_err;
    int          m_cnt;

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = '0;
        m_busy = 0;
        m_err  = 1'b0;
        m_cnt  = 0;
    endtask

    function automatic bit m_commit();
        return m_busy == 0 && !clear_req && wr_addr >= 1 && wr_addr < 32;
    endfunction

    function automatic logic [31:0] m_rd(input logic [31:0] a);
        if (m_busy > 0 || a >= 32 || a == 0) return '0;
`ifdef REG_FILE_BYPASS_EN
        if (m_commit() && a == wr_addr) return wr_data;
`endif
        return m_mem[a];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("rd_data1", rd_data1, m_rd(rd_addr1));
        chk("rd_data2", rd_data2, m_rd(rd_addr2));
        chk("busy", {31'd0, busy}, {31'd0, m_busy > 0});
        chk("addr_err", {31'd0, addr_err}, {31'd0, m_err});
        chk("wr_count", {16'd0, wr_count}, m_cnt);
    endtask

    task automatic edge_update();
        bit c, bad, clr;
        logic [31:0] wa, wd;
        c   = m_commit();
        bad = rd_addr1 >= 32 || rd_addr2 >= 32 || wr_addr >= 32;
        clr = clear_req;
        wa  = wr_addr;
        wd  = wr_data;
        @(posedge clk);
        if (m_busy > 0) begin
            m_busy--;
        end else if (clr) begin
            m_busy = 31;
            for (int i = 0; i < 32; i++) m_mem[i] = '0;
        end else if (c) begin
            m_mem[wa] = wd;
        end
        if (c && m_cnt < 65535) m_cnt++;
        if (bad) m_err = 1'b1;
        #1;
    endtask

    task automatic drive(input logic [31:0] wa, wd, ra1, ra2, input logic clr);
        wr_addr   = wa;
        wr_data   = wd;
        rd_addr1  = ra1;
        rd_addr2  = ra2;
        clear_req = clr;
    endtask

    task automatic cycle(input logic [31:0] wa, wd, ra1, ra2, input logic clr, input bit do_chk);
        drive(wa, wd, ra1, ra2, clr);
        #3;
        if (do_chk) check_model();
        edge_update();
    endtask

    // Asserts reset away from the clock edge and checks outputs respond at once.
    task automatic do_reset();
        drive(32'd5, 32'hFEED_F00D, 32'd5, 32'd7, 1'b0);
        reset_n = 1'b0;
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, addr_err}, 32'd0);
        chk("rst_cnt", {16'd0, wr_count}, 32'd0);
        chk("rst_rd1", rd_data1, 32'd0);
        chk("rst_rd2", rd_data2, 32'd0);
        m_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    function automatic logic [31:0] rnd_addr();
        int r;
        r = $urandom_range(0, 99);
        if (r < 5) return 32 + $urandom_range(0, 200);
        if (r < 7) return 32'h8000_0000 | $urandom_range(0, 31);
        return $urandom_range(0, 31);
    endfunction

    typedef struct {
        logic [31:0] wa, wd, ra1, ra2;
        logic [31:0] e1, e2;
        logic [15:0] ecnt;
        logic        eerr;
    } vec_t;

`ifdef REG_FILE_BYPASS_EN
    localparam logic [31:0] X7_SAME = 32'hA5A5_A5A5;
`else
    localparam logic [31:0] X7_SAME = 32'h0000_0011;
`endif

    vec_t vt [7];
    int   nbusy;

    initial begin
        vt[0] = '{32'd5,  32'hDEAD_BEEF, 32'd0,  32'd0, 32'd0,         32'd0,         16'd0, 1'b0};
        vt[1] = '{32'd0,  32'h0000_1234, 32'd5,  32'd0, 32'hDEAD_BEEF, 32'd0,         16'd1, 1'b0};
        vt[2] = '{32'd7,  32'h0000_0011, 32'd0,  32'd5, 32'd0,         32'hDEAD_BEEF, 16'd1, 1'b0};
        vt[3] = '{32'd7,  32'hA5A5_A5A5, 32'd0,  32'd7, 32'd0,         X7_SAME,       16'd2, 1'b0};
        vt[4] = '{32'd0,  32'd0,         32'd7,  32'd7, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 16'd3, 1'b0};
        vt[5] = '{32'd40, 32'hFFFF_FFFF, 32'd40, 32'd5, 32'd0,         32'hDEAD_BEEF, 16'd3, 1'b0};
        vt[6] = '{32'd0,  32'd0,         32'd5,  32'd0, 32'hDEAD_BEEF, 32'd0,         16'd3, 1'b1};

        #2;
        do_reset();

        for (int i = 0; i < 7; i++) begin
            drive(vt[i].wa, vt[i].wd, vt[i].ra1, vt[i].ra2, 1'b0);
            #3;
            chk($sformatf("vec%0d_rd1", i), rd_data1, vt[i].e1);
            chk($sformatf("vec%0d_rd2", i), rd_data2, vt[i].e2);
            chk($sformatf("vec%0d_cnt", i), {16'd0, wr_count}, {16'd0, vt[i].ecnt});
            chk($sformatf("vec%0d_err", i), {31'd0, addr_err}, {31'd0, vt[i].eerr});
            check_model();
            edge_update();
        end

        cycle(32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        chk("err_sticky", {31'd0, addr_err}, 32'd1);
        do_reset();
        cycle(32'd0, 32'd0, 32'd5, 32'd7, 1'b0, 1'b1);
        chk("err_after_rst", {31'd0, addr_err}, 32'd0);
        chk("x5_after_rst", rd_data1, 32'd0);

        for (int n = 0; n < 3000; n++) begin
            cycle(rnd_addr(), $urandom, rnd_addr(), rnd_addr(),
                  $urandom_range(0, 59) == 0, 1'b1);
        end
        while (m_busy > 0) cycle(32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);

        for (int i = 1; i < 32; i++) begin
            cycle(i, 32'hC0DE_0000 | i, i, 32'd0, 1'b0, 1'b1);
        end
        cycle(32'd3, 32'hBAD0_0003, 32'd3, 32'd4, 1'b1, 1'b1);
        nbusy = 0;
        for (int i = 0; i < 40; i++) begin
            drive(i < 20 ? 32'd9 : 32'd0, 32'h9999_9999, 32'd9, 32'd31, i == 2);
            #3;
            if (busy) nbusy++;
            check_model();
            edge_update();
        end
        chk("busy_cycles", nbusy, 32'd31);
        for (int i = 0; i < 32; i++) begin
            drive(32'd0, 32'd0, i, 31 - i, 1'b0);
            #3;
            chk($sformatf("clr_x%0d", i), rd_data1, 32'd0);
            check_model();
            edge_update();
        end

        for (int i = 1; i < 32; i++) begin
            cycle(i, 32'h5A5A_0000 | i, 32'd0, 32'd0, 1'b0, 1'b0);
        end
        cycle(32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) cycle(32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        do_reset();
        for (int i = 0; i < 32; i++) begin
            drive(32'd0, 32'd0, i, i, 1'b0);
            #3;
            chk($sformatf("abort_x%0d", i), rd_data2, 32'd0);
            check_model();
            edge_update();
        end

        for (int n = 0; m_cnt < 65534; n++) begin
            cycle(1 + (n % 31), n, 32'd0, 32'd0, 1'b0, 1'b0);
        end
        cycle(32'd4, 32'h4444_4444, 32'd4, 32'd0, 1'b0, 1'b1);
        cycle(32'd0, 32'd0, 32'd4, 32'd0, 1'b0, 1'b1);
        chk("cnt_sat", {16'd0, wr_count}, 32'h0000_FFFF);
        cycle(32'd6, 32'h6666_6666, 32'd0, 32'd0, 1'b0, 1'b1);
        cycle(32'd0, 32'd0, 32'd6, 32'd0, 1'b0, 1'b1);
        chk("cnt_hold", {16'd0, wr_count}, 32'h0000_FFFF);
        chk("x6_after_sat", rd_data1, 32'h6666_6666);

        $display("Result: errors=%0d of %0d checks", nerrs, nchecks);
        $finish;
    end

endmodule
